uart_regfile: RTL and testbench
===============================

// Module: uart_regfile
// PURPOSE
//  UART-driven parametrised register bank for the SDAD debug/control path.
//  Sits between UART_Rx/UART_Tx (or the mirror) and the fabric. Decodes
//  byte commands, writes N registers of W bits and answers read-back
//  requests over Tx. It replaces the fixed 4x4-bit registry with
//  multi-byte registers, read-back, a timeout and error recovery.
// PARAMETERS
//  C_CLK_FRQ        100_000_000  system clock [Hz]
//  C_UART_DATA_WIDTH 8           UART word width [bit]; fixed at 8
//  C_REG_COUNT      16           number of registers, 1..128
//  C_REG_WIDTH      16           register width [bit], 1..32
//  C_TIMEOUT        2            inter-byte timeout [ms]; 0 disables it
// PORTS
//  clk       in   1      system clock
//  rstb      in   1      synchronous reset, active low
//  rxValid   in   1      Rx byte available; held until rxAck
//  rxAck     out  1      one-cycle pulse: Rx byte consumed
//  rxData    in   8      Rx byte
//  rxErr     in   1      Rx framing/parity error
//  txBusy    in   1      Tx transmitter busy
//  txSend    out  1      one-cycle pulse: load txData
//  txData    out  8      Tx byte
//  txErr     in   1      Tx error (aborts the response)
//  regs      out  C_REG_COUNT*C_REG_WIDTH  flat register image; reg i at [(i+1)*W-1:i*W]
//  wstrb     out  C_REG_COUNT  one-cycle pulse per register on write commit
//  busy      out  1      high whenever the FSM is not in IDLE
// BEHAVIOUR
//  - Reset (rstb=0 at a clk edge) zeroes regs, wstrb, rxAck, txSend, txData and busy. FSM goes to IDLE, with effect on the same edge at any state.
//  - NB = ceil(C_REG_WIDTH/8). Header byte: bit7=1 write / 0 read; bits[6:0]=addr.
//  - Write frame = header + NB data bytes, LSB byte first. Bits of the last byte above W are ignored.
//  - Read frame = header only. Response = NB bytes, LSB first, zero-padded above W.
//  - Rx handshake: byte accepted when rxValid=1 in IDLE or DATA. rxAck high one cycle. Next byte is not sampled until rxValid has been seen low.
//  - Tx handshake: txSend is pulsed only when txBusy=0. The FSM then waits for txBusy=1 and then txBusy=0 before the next byte.
//  - States: IDLE -> (write hdr) DATA -> COMMIT -> IDLE.
//            IDLE -> (read hdr) TX_LOAD -> TX_WAIT_HI -> TX_WAIT_LO -> TX_LOAD... -> IDLE after NB bytes.
//  - COMMIT: regs[addr] updated and wstrb[addr]=1 for exactly one cycle. Write latency is 1 clk after the last data byte is acked.
//  - addr >= C_REG_COUNT:
//      write: data bytes are consumed and discarded; no strobe.
//      read: a single NAK byte 8'h15 is sent instead of data.
//  - rxErr=1 with rxValid: the byte is acked and discarded. Any partial frame is dropped and the FSM returns to IDLE.
//  - Timeout: a counter is cleared on each accepted byte. If it reaches C_TIMEOUT ms while in DATA, the partial write is dropped and the FSM goes to IDLE.
//  - txErr=1 in any TX_* state: the rest of the response is abandoned and the FSM goes to IDLE.
//  - Rx bytes arriving during TX_* states stay pending (no ack) until IDLE.
//  - The byte counter wraps only through the frame logic; never exceeds NB-1.
// CONFIGURATION
//  Macro UART_REGFILE_WRITE_ACK_EN.
//   Defined: after COMMIT the block sends ACK byte 8'h06 through the Tx states.
//            An invalid-address write sends NAK 8'h15.
//   Undefined: writes are silent; txSend never pulses for write frames.
// STRUCTURE
//  - Package sdad_uart_pkg holds:
//      the ACK/NAK constants (8'h06, 8'h15),
//      the header bit positions,
//      the FSM state encoding,
//      the ms-to-cycles helper function.
//  - One sub-module: uart_tx_seq. It owns TX_LOAD/TX_WAIT_HI/TX_WAIT_LO, serialises an NB-byte word and has a byte-count input.
//  - The top FSM, register array and timeout counter stay in uart_regfile.
// TESTING
//  1. Write reg 3 = 16'hBEEF (rx 8'h83, 8'hEF, 8'hBE) -> regs[63:48]=16'hBEEF, wstrb=16'h0008 for 1 clk.
//  2. Read reg 3 after test 1 (rx 8'h03) -> tx 8'hEF then 8'hBE. txSend each only while txBusy=0.
//  3. Read addr 8'h20 (>15) -> single tx 8'h15. Write 8'hA0,8'h11,8'h22 -> no wstrb, regs unchanged.
//  4. Rx 8'h85,8'h12 then idle 3 ms -> timeout to IDLE. Then rx 8'h85,8'h34,8'h56 -> regs[5]=16'h5634.
//  5. rxErr on 2nd byte of a write -> byte acked, frame dropped, no strobe. A following valid write is accepted.
//  6. rstb=0 mid-read (during TX_WAIT_LO) -> next clk all regs 0, busy=0, txSend=0.
//     With UART_REGFILE_WRITE_ACK_EN: test 1 also emits 8'h06.

Source files
------------

// File: rtl/sdad_uart_pkg.sv
// Shared definitions for the UART register bank: protocol bytes, header
// layout, FSM state encodings and the millisecond-to-cycle conversion.
// Used by uart_regfile and uart_tx_seq. The optional write acknowledge is
// selected in uart_regfile with the macro UART_REGFILE_WRITE_ACK_EN.
package sdad_uart_pkg;

  // Response bytes
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  // Header byte layout: bit 7 selects write (1) / read (0), bits 6..0 address
  localparam int unsigned HDR_WR_BIT    = 7;
  localparam int unsigned HDR_ADDR_MSB  = 6;
  localparam int unsigned HDR_ADDR_LSB  = 0;

  // Frame-level FSM owned by uart_regfile
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_TX     = 2'd3
  } rf_state_e;

  // Byte transmit FSM owned by uart_tx_seq
  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_LOAD    = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_e;

  // Number of clock cycles in a given number of milliseconds
  function automatic int unsigned ms_to_cycles(input int unsigned clk_frq,
                                               input int unsigned ms);
    return (clk_frq / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// Transmit sequencer: sends the low nbytes bytes of a 32-bit word over the
// UART Tx handshake, LSB byte first. Each byte is loaded only while the
// transmitter is idle, then the sequencer waits for busy to rise and fall.
// A Tx error abandons the remaining bytes. done_o pulses once at the end.
module uart_tx_seq
  import sdad_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rstb,
  input  logic        start_i,
  input  logic [31:0] word_i,
  input  logic [2:0]  nbytes_i,
  input  logic        tx_busy_i,
  input  logic        tx_err_i,
  output logic        tx_send_o,
  output logic [7:0]  tx_data_o,
  output logic        done_o
);

  tx_state_e   state_q;
  logic [31:0] word_q;
  logic [2:0]  nbytes_q;
  logic [2:0]  cnt_q;
  logic        tx_send_q;
  logic [7:0]  tx_data_q;
  logic        done_q;

  // Byte transmit state machine with registered send/data/done outputs
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q   <= TX_IDLE;
      word_q    <= 32'd0;
      nbytes_q  <= 3'd0;
      cnt_q     <= 3'd0;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      tx_send_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (start_i) begin
            word_q   <= word_i;
            nbytes_q <= nbytes_i;
            cnt_q    <= 3'd0;
            state_q  <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          if (tx_err_i) begin
            done_q  <= 1'b1;
            state_q <= TX_IDLE;
          end else if (!tx_busy_i) begin
            tx_send_q <= 1'b1;
            tx_data_q <= word_q[7:0];
            word_q    <= {8'd0, word_q[31:8]};
            state_q   <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          if (tx_err_i) begin
            done_q  <= 1'b1;
            state_q <= TX_IDLE;
          end else if (tx_busy_i) begin
            state_q <= TX_WAIT_LO;
          end
        end
        TX_WAIT_LO: begin
          if (tx_err_i) begin
            done_q  <= 1'b1;
            state_q <= TX_IDLE;
          end else if (!tx_busy_i) begin
            if (cnt_q == (nbytes_q - 3'd1)) begin
              done_q  <= 1'b1;
              state_q <= TX_IDLE;
            end else begin
              cnt_q   <= cnt_q + 3'd1;
              state_q <= TX_LOAD;
            end
          end
        end
        default: begin
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx_send_o = tx_send_q;
  assign tx_data_o = tx_data_q;
  assign done_o    = done_q;

endmodule

// File: rtl/uart_regfile.sv
// UART-driven register bank. Decodes header/data byte frames from the Rx
// side, writes C_REG_COUNT registers of C_REG_WIDTH bits and answers
// read requests through uart_tx_seq. Handles invalid addresses (NAK on
// read, discard on write), Rx errors and an inter-byte timeout.
// Optional feature: define UART_REGFILE_WRITE_ACK_EN to answer each write
// frame with ACK (valid address) or NAK (invalid address).
module uart_regfile
  import sdad_uart_pkg::*;
#(
  parameter int unsigned C_CLK_FRQ         = 100_000_000,
  parameter int unsigned C_UART_DATA_WIDTH = 8,
  parameter int unsigned C_REG_COUNT       = 16,
  parameter int unsigned C_REG_WIDTH       = 16,
  parameter int unsigned C_TIMEOUT         = 2
)(
  input  logic                                 clk,
  input  logic                                 rstb,
  input  logic                                 rxValid,
  output logic                                 rxAck,
  input  logic [C_UART_DATA_WIDTH-1:0]         rxData,
  input  logic                                 rxErr,
  input  logic                                 txBusy,
  output logic                                 txSend,
  output logic [C_UART_DATA_WIDTH-1:0]         txData,
  input  logic                                 txErr,
  output logic [C_REG_COUNT*C_REG_WIDTH-1:0]   regs,
  output logic [C_REG_COUNT-1:0]               wstrb,
  output logic                                 busy
);

  localparam int unsigned NB        = (C_REG_WIDTH + 7) / 8;
  localparam int unsigned AW        = (C_REG_COUNT > 1) ? $clog2(C_REG_COUNT) : 1;
  localparam int unsigned TO_CYCLES = ms_to_cycles(C_CLK_FRQ, C_TIMEOUT);
  localparam logic [1:0]  LAST_BYTE = 2'(NB - 1);
  localparam logic [7:0]  REG_CNT_8 = 8'(C_REG_COUNT);

  rf_state_e              state_q;
  logic [6:0]             addr_q;
  logic [1:0]             byte_cnt_q;
  logic [C_REG_WIDTH-1:0] wdata_q;
  logic [C_REG_WIDTH-1:0] regs_q [C_REG_COUNT];
  logic [C_REG_COUNT-1:0] wstrb_q;
  logic                   rx_ack_q;
  logic                   rx_armed_q;
  logic                   tx_start_q;
  logic [31:0]            tx_word_q;
  logic [2:0]             tx_nbytes_q;
  logic [31:0]            to_cnt_q;

  logic                   rx_accept_s;
  logic                   hdr_wr_s;
  logic [6:0]             hdr_addr_s;
  logic                   hdr_valid_s;
  logic                   addr_valid_s;
  logic                   timeout_s;
  logic [31:0]            rd_word_s;
  logic                   tx_done_s;

  // Header decode, Rx accept qualification and read-back word selection
  always_comb begin
    rx_accept_s  = rxValid && rx_armed_q &&
                   ((state_q == ST_IDLE) || (state_q == ST_DATA));
    hdr_wr_s     = rxData[HDR_WR_BIT];
    hdr_addr_s   = rxData[HDR_ADDR_MSB:HDR_ADDR_LSB];
    hdr_valid_s  = ({1'b0, hdr_addr_s} < REG_CNT_8);
    addr_valid_s = ({1'b0, addr_q} < REG_CNT_8);
    timeout_s    = (C_TIMEOUT != 32'd0) && (state_q == ST_DATA) &&
                   (to_cnt_q >= 32'(TO_CYCLES));
    rd_word_s    = 32'd0;
    rd_word_s[C_REG_WIDTH-1:0] = regs_q[hdr_addr_s[AW-1:0]];
  end

  // Rx handshake: ack pulse per accepted byte, re-arm only after rxValid drops
  always_ff @(posedge clk) begin
    if (!rstb) begin
      rx_ack_q   <= 1'b0;
      rx_armed_q <= 1'b1;
    end else begin
      rx_ack_q <= rx_accept_s;
      if (rx_accept_s) begin
        rx_armed_q <= 1'b0;
      end else if (!rxValid) begin
        rx_armed_q <= 1'b1;
      end else begin
        rx_armed_q <= rx_armed_q;
      end
    end
  end

  // Inter-byte timeout counter, runs only while collecting write data
  always_ff @(posedge clk) begin
    if (!rstb) begin
      to_cnt_q <= 32'd0;
    end else if (rx_accept_s || (state_q != ST_DATA)) begin
      to_cnt_q <= 32'd0;
    end else if (to_cnt_q < 32'(TO_CYCLES)) begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end else begin
      to_cnt_q <= to_cnt_q;
    end
  end

  // Frame FSM: header decode, data collection, commit and response launch
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      addr_q      <= 7'd0;
      byte_cnt_q  <= 2'd0;
      wdata_q     <= {C_REG_WIDTH{1'b0}};
      wstrb_q     <= {C_REG_COUNT{1'b0}};
      tx_start_q  <= 1'b0;
      tx_word_q   <= 32'd0;
      tx_nbytes_q <= 3'd0;
      for (int i = 0; i < int'(C_REG_COUNT); i++) begin
        regs_q[i] <= {C_REG_WIDTH{1'b0}};
      end
    end else begin
      wstrb_q    <= {C_REG_COUNT{1'b0}};
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_accept_s) begin
            if (rxErr) begin
              state_q <= ST_IDLE;
            end else if (hdr_wr_s) begin
              addr_q     <= hdr_addr_s;
              byte_cnt_q <= 2'd0;
              wdata_q    <= {C_REG_WIDTH{1'b0}};
              state_q    <= ST_DATA;
            end else begin
              addr_q     <= hdr_addr_s;
              tx_start_q <= 1'b1;
              if (hdr_valid_s) begin
                tx_word_q   <= rd_word_s;
                tx_nbytes_q <= 3'(NB);
              end else begin
                tx_word_q   <= {24'd0, NAK_BYTE};
                tx_nbytes_q <= 3'd1;
              end
              state_q <= ST_TX;
            end
          end
        end
        ST_DATA: begin
          if (rx_accept_s) begin
            if (rxErr) begin
              byte_cnt_q <= 2'd0;
              state_q    <= ST_IDLE;
            end else begin
              // Bits of the last byte above the register width are dropped
              for (int b = 0; b < int'(C_REG_WIDTH); b++) begin
                if ((b / 8) == int'(byte_cnt_q)) begin
                  wdata_q[b] <= rxData[b % 8];
                end
              end
              if (byte_cnt_q == LAST_BYTE) begin
                byte_cnt_q <= 2'd0;
                state_q    <= ST_COMMIT;
              end else begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
              end
            end
          end else if (timeout_s) begin
            byte_cnt_q <= 2'd0;
            state_q    <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          if (addr_valid_s) begin
            regs_q[addr_q[AW-1:0]]  <= wdata_q;
            wstrb_q[addr_q[AW-1:0]] <= 1'b1;
          end
`ifdef UART_REGFILE_WRITE_ACK_EN
          tx_start_q  <= 1'b1;
          tx_word_q   <= {24'd0, (addr_valid_s ? ACK_BYTE : NAK_BYTE)};
          tx_nbytes_q <= 3'd1;
          state_q     <= ST_TX;
`else
          state_q     <= ST_IDLE;
`endif
        end
        ST_TX: begin
          if (tx_done_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_seq u_tx_seq (
    .clk       (clk),
    .rstb      (rstb),
    .start_i   (tx_start_q),
    .word_i    (tx_word_q),
    .nbytes_i  (tx_nbytes_q),
    .tx_busy_i (txBusy),
    .tx_err_i  (txErr),
    .tx_send_o (txSend),
    .tx_data_o (txData),
    .done_o    (tx_done_s)
  );

  for (genvar g = 0; g < int'(C_REG_COUNT); g++) begin : g_flat
    assign regs[g*C_REG_WIDTH +: C_REG_WIDTH] = regs_q[g];
  end

  assign rxAck = rx_ack_q;
  assign wstrb = wstrb_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_regfile.sv
// Directed bench for uart_regfile: a table of read/write frames with
// hand-computed results, plus sequences for timeout, Rx error, Tx error,
// pending Rx during a response and reset in the middle of a read.
module tb_uart_regfile;

  localparam int unsigned CLK_FRQ = 10_000;  // 10 cycles per ms
  localparam int unsigned RC      = 16;
  localparam int unsigned RW      = 16;

  logic           clk = 1'b0;
  logic           rstb;
  logic           rxValid;
  logic           rxAck;
  logic [7:0]     rxData;
  logic           rxErr;
  logic           txBusy;
  logic           txSend;
  logic [7:0]     txData;
  logic           txErr;
  logic [255:0]   regs;
  logic [15:0]    wstrb;
  logic           busy;

  int             nvec = 0;
  int             nerr = 0;
  logic [7:0]     txq[$];
  logic [15:0]    strb_acc;
  int             strb_cnt;
  logic [255:0]   exp_img;

  uart_regfile #(
    .C_CLK_FRQ(CLK_FRQ), .C_UART_DATA_WIDTH(8), .C_REG_COUNT(RC),
    .C_REG_WIDTH(RW), .C_TIMEOUT(2)
  ) dut (
    .clk(clk), .rstb(rstb), .rxValid(rxValid), .rxAck(rxAck),
    .rxData(rxData), .rxErr(rxErr), .txBusy(txBusy), .txSend(txSend),
    .txData(txData), .txErr(txErr), .regs(regs), .wstrb(wstrb), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_wstrb;
    int          exp_ntx;
    logic [15:0] exp_tx;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    int n;
    rxData = b; rxErr = e; rxValid = 1'b1; n = 0;
    do begin
      @(negedge clk); n++;
    end while (!rxAck && n < 400);
    if (!rxAck) begin
      nvec++; nerr++;
      $display("FAIL rx_ack_timeout: byte %0h never acked", b);
    end
    rxValid = 1'b0; rxErr = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk); n++;
    end
    if (busy) begin
      nvec++; nerr++;
      $display("FAIL busy_timeout: busy stuck at 1, expected 0");
    end
  endtask

  // Tx side model: takes each byte, then stays busy for a few cycles
  initial begin
    txBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (txSend) begin
        txq.push_back(txData);
        txBusy = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (txSend) begin
            nerr++;
            $display("FAIL txsend_while_busy: txSend 1 while txBusy 1");
          end
        end
        txBusy = 1'b0;
      end
    end
  end

  // Strobe monitor: OR of all strobes and number of strobe cycles
  initial begin
    strb_acc = 16'h0000; strb_cnt = 0;
    forever begin
      @(negedge clk);
      if (wstrb != 16'h0000) begin
        strb_acc = strb_acc | wstrb;
        strb_cnt++;
      end
    end
  end

  initial begin
    int          ntx;
    int          n;
    logic [15:0] etx;
    vecs[0]  = '{1'b1, 7'h03, 16'hBEEF, 16'h0008, 0, 16'h0000};
    vecs[1]  = '{1'b0, 7'h03, 16'h0000, 16'h0000, 2, 16'hBEEF};
    vecs[2]  = '{1'b0, 7'h20, 16'h0000, 16'h0000, 1, 16'h0015};
    vecs[3]  = '{1'b1, 7'h20, 16'h2211, 16'h0000, 0, 16'h0000};
    vecs[4]  = '{1'b1, 7'h00, 16'h1234, 16'h0001, 0, 16'h0000};
    vecs[5]  = '{1'b1, 7'h0F, 16'hFFFF, 16'h8000, 0, 16'h0000};
    vecs[6]  = '{1'b0, 7'h0F, 16'h0000, 16'h0000, 2, 16'hFFFF};
    vecs[7]  = '{1'b0, 7'h00, 16'h0000, 16'h0000, 2, 16'h1234};
    vecs[8]  = '{1'b1, 7'h03, 16'h0001, 16'h0008, 0, 16'h0000};
    vecs[9]  = '{1'b0, 7'h03, 16'h0000, 16'h0000, 2, 16'h0001};
    vecs[10] = '{1'b0, 7'h05, 16'h0000, 16'h0000, 2, 16'h0000};
    vecs[11] = '{1'b0, 7'h7F, 16'h0000, 16'h0000, 1, 16'h0015};
    vecs[12] = '{1'b1, 7'h10, 16'hABCD, 16'h0000, 0, 16'h0000};
    vecs[13] = '{1'b0, 7'h10, 16'h0000, 16'h0000, 1, 16'h0015};

    rstb = 1'b0; rxValid = 1'b0; rxData = 8'h00; rxErr = 1'b0; txErr = 1'b0;
    exp_img = 256'd0;
    repeat (3) @(negedge clk);
    chk("reset_regs", regs, 256'd0);
    chk("reset_wstrb", wstrb, 256'd0);
    chk("reset_busy", busy, 256'd0);
    chk("reset_txsend", txSend, 256'd0);
    chk("reset_rxack", rxAck, 256'd0);
    chk("reset_txdata", txData, 256'd0);
    rstb = 1'b1;
    @(negedge clk);

    // Table of frames
    for (int i = 0; i < 14; i++) begin
      txq.delete(); strb_acc = 16'h0000; strb_cnt = 0;
      send_byte({vecs[i].wr, vecs[i].addr}, 1'b0);
      if (vecs[i].wr) begin
        send_byte(vecs[i].wdata[7:0], 1'b0);
        send_byte(vecs[i].wdata[15:8], 1'b0);
      end
      wait_idle();
      chk($sformatf("v%0d_wstrb", i), strb_acc, vecs[i].exp_wstrb);
      chk($sformatf("v%0d_wstrb_cycles", i), strb_cnt, (vecs[i].exp_wstrb != 16'h0000) ? 1 : 0);
      if (vecs[i].wr && vecs[i].exp_wstrb != 16'h0000)
        exp_img[int'(vecs[i].addr)*16 +: 16] = vecs[i].wdata;
      chk($sformatf("v%0d_regs", i), regs, exp_img);
      ntx = vecs[i].exp_ntx; etx = vecs[i].exp_tx;
`ifdef UART_REGFILE_WRITE_ACK_EN
      if (vecs[i].wr) begin
        ntx = 1;
        etx = (vecs[i].exp_wstrb != 16'h0000) ? 16'h0006 : 16'h0015;
      end
`endif
      chk($sformatf("v%0d_tx_count", i), txq.size(), ntx);
      for (int k = 0; k < ntx; k++) begin
        if (k < txq.size())
          chk($sformatf("v%0d_tx_byte%0d", i, k), txq[k], etx[k*8 +: 8]);
        else begin
          nvec++; nerr++;
          $display("FAIL v%0d_tx_byte%0d: got nothing expected %0h", i, k, etx[k*8 +: 8]);
        end
      end
    end

    // Timeout: partial write dropped after 3 ms of silence
    strb_acc = 16'h0000; strb_cnt = 0;
    send_byte(8'h85, 1'b0);
    send_byte(8'h12, 1'b0);
    repeat (30) @(negedge clk);
    chk("timeout_busy", busy, 256'd0);
    chk("timeout_no_strobe", strb_cnt, 256'd0);
    send_byte(8'h85, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    wait_idle();
    exp_img[5*16 +: 16] = 16'h5634;
    chk("timeout_reg5", regs[5*16 +: 16], 16'h5634);
    chk("timeout_wstrb", strb_acc, 16'h0020);

    // Rx error on the second byte drops the frame
    strb_acc = 16'h0000; strb_cnt = 0;
    send_byte(8'h82, 1'b0);
    send_byte(8'h44, 1'b1);
    repeat (2) @(negedge clk);
    chk("rxerr_busy", busy, 256'd0);
    chk("rxerr_no_strobe", strb_cnt, 256'd0);
    chk("rxerr_reg2", regs[2*16 +: 16], 16'h0000);
    send_byte(8'h82, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    wait_idle();
    exp_img[2*16 +: 16] = 16'h3344;
    chk("rxerr_next_reg2", regs[2*16 +: 16], 16'h3344);
    chk("rxerr_next_wstrb", strb_acc, 16'h0004);
    chk("rxerr_next_regs", regs, exp_img);

    // Tx error abandons the response before any byte is sent
    txq.delete();
    txErr = 1'b1;
    send_byte(8'h03, 1'b0);
    wait_idle();
    txErr = 1'b0;
    chk("txerr_tx_count", txq.size(), 256'd0);

    // Rx byte arriving during a response waits until the FSM is idle
    txq.delete();
    send_byte(8'h03, 1'b0);
    rxData = 8'h00; rxErr = 1'b0; rxValid = 1'b1; n = 0;
    do begin
      @(negedge clk); n++;
    end while (!rxAck && n < 400);
    chk("pending_acked", rxAck, 256'd1);
    chk("pending_order", txq.size(), 256'd2);
    rxValid = 1'b0;
    @(negedge clk);
    wait_idle();
    chk("pending_tx_count", txq.size(), 256'd4);
    if (txq.size() == 4) begin
      chk("pending_b0", txq[0], 8'h01);
      chk("pending_b1", txq[1], 8'h00);
      chk("pending_b2", txq[2], 8'h34);
      chk("pending_b3", txq[3], 8'h12);
    end

    // Reset while waiting for the transmitter to go idle
    send_byte(8'h0F, 1'b0);
    n = 0;
    while (!txBusy && n < 200) begin
      @(negedge clk); n++;
    end
    chk("midread_tx_started", txBusy, 256'd1);
    @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    chk("midread_regs", regs, 256'd0);
    chk("midread_busy", busy, 256'd0);
    chk("midread_txsend", txSend, 256'd0);
    chk("midread_txdata", txData, 256'd0);
    chk("midread_wstrb", wstrb, 256'd0);
    rstb = 1'b1;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
